// File: rtl/frame_pkg.sv
// Shared sizing and state encoding for the frame buffer arbiter slice.
package frame_pkg;
  localparam int N      = 13;
  localparam int W      = 16;
  localparam int PIXELS = 6144;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;
endpackage

// File: rtl/frame_clear_counter.sv
// Address sweep for the full-frame clear: restarts on start, advances only on a granted step.
// Saturates at PIXELS-1 and flags it; no wrap-around.
module frame_clear_counter #(
  parameter int N      = frame_pkg::N,
  parameter int PIXELS = frame_pkg::PIXELS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         step,
  output logic [N-1:0] clr_cnt,
  output logic         last
);
  localparam logic [N-1:0] LAST_CNT = N'(PIXELS - 1);

  assign last = (clr_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_cnt <= '0;
    end else if (start) begin
      clr_cnt <= '0;
    end else if (step && !last) begin
      clr_cnt <= clr_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/frame_buffer_arbiter.sv
// Single-port frame BRAM arbiter: display > writer > clear, one combinational grant per cycle.
// Display reads return in 2 cycles and are never stalled; writer waits for IDLE and no display.
module frame_buffer_arbiter #(
  parameter int N      = frame_pkg::N,
  parameter int W      = frame_pkg::W,
  parameter int PIXELS = frame_pkg::PIXELS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         disp_req,
  input  logic [N-1:0] disp_addr,
  output logic         disp_valid,
  output logic [W-1:0] disp_data,
  input  logic         wr_req,
  input  logic [N-1:0] wr_addr,
  input  logic [W-1:0] wr_data,
  output logic         wr_ack,
  input  logic         clr_start,
  input  logic [W-1:0] clr_color,
  output logic         busy,
  output logic         clr_done,
  output logic [N-1:0] mem_addr,
  output logic         mem_we,
  output logic [W-1:0] mem_wdata,
  input  logic [W-1:0] mem_rdata
);
  import frame_pkg::*;

  state_t       state;
  logic [W-1:0] clr_color_q;
  logic [W-1:0] wdata_q;
  logic [N-1:0] addr_q;
  logic [N-1:0] clr_cnt;
  logic         clr_last;
  logic         clr_go;
  logic         disp_gnt;
  logic         wr_gnt;
  logic         clr_gnt;
  logic         rd_p1;

  // Reset blocks every grant so the BRAM never sees a stray write during abort.
  assign disp_gnt = !reset && disp_req;
  assign wr_gnt   = !reset && !disp_req && wr_req && (state == ST_IDLE);
  assign clr_gnt  = !reset && !disp_req && (state == ST_CLEAR);
  assign clr_go   = (state == ST_IDLE) && clr_start;
  assign wr_ack   = wr_gnt;

  frame_clear_counter #(
    .N      (N),
    .PIXELS (PIXELS)
  ) u_clear_counter (
    .clk     (clk),
    .reset   (reset),
    .start   (clr_go),
    .step    (clr_gnt),
    .clr_cnt (clr_cnt),
    .last    (clr_last)
  );

  always_comb begin
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_we    = 1'b0;
    if (reset) begin
      mem_addr  = '0;
      mem_wdata = '0;
    end else if (disp_gnt) begin
      mem_addr = disp_addr;
    end else if (wr_gnt) begin
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
      mem_we    = 1'b1;
    end else if (clr_gnt) begin
      mem_addr  = clr_cnt;
      mem_wdata = clr_color_q;
      mem_we    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      clr_done    <= 1'b0;
      clr_color_q <= '0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clr_start) begin
            state       <= ST_CLEAR;
            busy        <= 1'b1;
            clr_color_q <= clr_color;
          end
        end
        ST_CLEAR: begin
          if (clr_gnt && clr_last) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            clr_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // BRAM output is valid one cycle after the grant; capture it the cycle after that.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_p1      <= 1'b0;
      disp_valid <= 1'b0;
      disp_data  <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      rd_p1      <= disp_gnt;
      disp_valid <= rd_p1;
      if (rd_p1) disp_data <= mem_rdata;
      addr_q     <= mem_addr;
      wdata_q    <= mem_wdata;
    end
  end
endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed bench for frame_buffer_arbiter with a behavioural one-cycle-read BRAM.
module tb_frame_buffer_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        disp_req;
  logic [12:0] disp_addr;
  logic        disp_valid;
  logic [15:0] disp_data;
  logic        wr_req;
  logic [12:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic        clr_start;
  logic [15:0] clr_color;
  logic        busy;
  logic        clr_done;
  logic [12:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] bram [0:8191];

  int n_cmp = 0;
  int n_err = 0;

  frame_buffer_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .clr_start  (clr_start),
    .clr_color  (clr_color),
    .busy       (busy),
    .clr_done   (clr_done),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) bram[mem_addr] <= mem_wdata;
    mem_rdata <= bram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic read_px(input logic [12:0] a, input logic [15:0] e, input string tag);
    @(posedge clk); #1;
    disp_req  = 1'b1;
    disp_addr = a;
    @(negedge clk);
    chk({tag, "_we"}, mem_we, 0);
    @(posedge clk); #1;
    disp_req = 1'b0;
    @(negedge clk);
    chk({tag, "_early"}, disp_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_data"}, {disp_valid, disp_data}, {1'b1, e});
  endtask

  initial begin
    int busy_cyc, done_at, grants, ack_c;
    logic ack_busy;

    for (int i = 0; i < 8192; i++) bram[i] = 16'h0000;
    bram[0]     = 16'hA5A5;
    bram[6143]  = 16'h5A5A;
    bram[6144]  = 16'h1234;

    // Reset with requests present: nothing may reach the BRAM.
    reset = 1'b1; disp_req = 1'b1; disp_addr = 13'h55;
    wr_req = 1'b1; wr_addr = 13'h66; wr_data = 16'hFFFF;
    clr_start = 1'b0; clr_color = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_flags", {disp_valid, busy, clr_done, wr_ack, mem_we}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_ddata", disp_data, 0);
    disp_req = 1'b0; wr_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // Back-to-back display reads.
    @(posedge clk); #1;
    disp_req = 1'b1; disp_addr = 13'h0000;
    @(negedge clk);
    chk("b2b_a0", {mem_we, mem_addr}, {1'b0, 13'h0000});
    @(posedge clk); #1;
    disp_addr = 13'h17FF;
    @(negedge clk);
    chk("b2b_a1", {mem_we, mem_addr}, {1'b0, 13'h17FF});
    chk("b2b_nv", disp_valid, 0);
    @(posedge clk); #1;
    disp_req = 1'b0;
    @(negedge clk);
    chk("b2b_d0", {disp_valid, disp_data}, {1'b1, 16'hA5A5});
    @(posedge clk);
    @(negedge clk);
    chk("b2b_d1", {disp_valid, disp_data}, {1'b1, 16'h5A5A});
    @(posedge clk);
    @(negedge clk);
    chk("b2b_hold", {disp_valid, disp_data}, {1'b0, 16'h5A5A});

    // Writer with no display traffic: acked the same cycle.
    @(posedge clk); #1;
    wr_req = 1'b1; wr_addr = 13'h0010; wr_data = 16'hF800;
    @(negedge clk);
    chk("wr_ack", {wr_ack, mem_we}, 2'b11);
    chk("wr_bus", {mem_addr, mem_wdata}, {13'h0010, 16'hF800});
    @(posedge clk); #1;
    wr_req = 1'b0;
    read_px(13'h0010, 16'hF800, "rd_wr");

    // Writer held behind 5 cycles of display reads.
    @(posedge clk); #1;
    wr_req = 1'b1; wr_addr = 13'h0020; wr_data = 16'h001F;
    disp_req = 1'b1; disp_addr = 13'h0010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("wr_blocked", {wr_ack, mem_we}, 2'b00);
      @(posedge clk); #1;
      if (i == 4) disp_req = 1'b0;
    end
    @(negedge clk);
    chk("wr_late", {wr_ack, mem_we, mem_addr}, {2'b11, 13'h0020});
    @(posedge clk); #1;
    wr_req = 1'b0;
    read_px(13'h0020, 16'h001F, "rd_wr2");

    // Full clear with no traffic.
    @(posedge clk); #1;
    clr_start = 1'b1; clr_color = 16'h07E0;
    @(negedge clk);
    chk("clr_busy0", busy, 0);
    @(posedge clk); #1;
    clr_start = 1'b0; clr_color = 16'h0000;
    busy_cyc = 0; done_at = 0;
    for (int c = 1; c <= 7000; c++) begin
      @(negedge clk);
      if (c == 1) chk("clr_first", {mem_we, mem_addr, mem_wdata}, {1'b1, 13'h0000, 16'h07E0});
      if (busy) busy_cyc++;
      if (clr_done) begin
        done_at = c;
        break;
      end
      @(posedge clk);
    end
    chk("clr_busy_len", busy_cyc, 6144);
    chk("clr_done_at", done_at, 6145);
    @(posedge clk);
    @(negedge clk);
    chk("clr_pulse", {clr_done, busy}, 2'b00);
    read_px(13'd0, 16'h07E0, "clr_0");
    read_px(13'd3000, 16'h07E0, "clr_3000");
    read_px(13'd6143, 16'h07E0, "clr_6143");
    read_px(13'd6144, 16'h1234, "clr_6144");

    // Clear stretched by alternate-cycle display reads; writer waits for IDLE.
    @(posedge clk); #1;
    clr_start = 1'b1; clr_color = 16'hF81F;
    @(posedge clk); #1;
    clr_start = 1'b0;
    grants = 0; done_at = 0; ack_c = 0; ack_busy = 1'b1;
    for (int c = 1; c <= 20000; c++) begin
      if (ack_c != 0) wr_req = 1'b0;
      if (c == 100) begin
        wr_req = 1'b1; wr_addr = 13'h0030; wr_data = 16'h1234;
      end
      disp_req  = c[0];
      disp_addr = 13'h0005;
      @(negedge clk);
      if (disp_req && busy) grants++;
      if (wr_ack && ack_c == 0) begin
        ack_c    = c;
        ack_busy = busy;
      end
      if (clr_done && done_at == 0) done_at = c;
      if (done_at != 0 && ack_c != 0) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    disp_req = 1'b0; wr_req = 1'b0;
    chk("str_grants", grants, 6144);
    chk("str_done_at", done_at, 12289);
    chk("str_ack_at", ack_c, 12290);
    chk("str_ack_busy", ack_busy, 0);
    read_px(13'h0030, 16'h1234, "str_wr");
    read_px(13'h0005, 16'hF81F, "str_5");

    // Reset while clr_cnt = 100.
    @(posedge clk); #1;
    clr_start = 1'b1; clr_color = 16'h001F;
    @(posedge clk); #1;
    clr_start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_we", mem_we, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_flags", {busy, clr_done, mem_we}, 3'b000);
    @(posedge clk); #1;
    wr_req = 1'b1; wr_addr = 13'h0040; wr_data = 16'h0ABC;
    @(negedge clk);
    chk("abort_idle", wr_ack, 1);
    @(posedge clk); #1;
    wr_req = 1'b0;
    @(negedge clk);
    chk("abort_nodone", {busy, clr_done}, 2'b00);
    read_px(13'd99, 16'h001F, "abort_99");
    read_px(13'd100, 16'hF81F, "abort_100");
    read_px(13'h0040, 16'h0ABC, "abort_wr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
